time_ascii_sender: RTL and testbench

TIME_ASCII_SENDER -- requirements
Module: time_ascii_sender

---
 rtl/time_ascii_sender.sv | 124 ++++++++++++
 tb/tb_time_ascii_sender.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_ascii_sender.sv
// rtl/time_ascii_sender.sv - snapshots stopwatch time and pushes "HH:MM:SS.CC" plus terminator as ASCII bytes.
// Optional TIME_SENDER_CRLF_EN: terminate with CR LF instead of LF alone.
module time_ascii_sender #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter logic [7:0] DOT_CHAR = 8'h2E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_full,
  output logic       push,
  output logic [7:0] push_data,
  output logic       busy,
  output logic       done
);

`ifdef TIME_SENDER_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd12;
`else
  localparam logic [3:0] LAST_IDX = 4'd11;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t     state, next_state;
  logic [3:0] idx;
  logic [4:0] hour_q;
  logic [5:0] min_q, sec_q;
  logic [6:0] msec_q;
  logic [7:0] h1, h0, m1, m0, s1, s0, c1, c0;
  logic [7:0] frame_byte;

  // Values of 100 and above saturate to "99"; leading zeros are kept.
  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] s;
    s = (v > 7'd99) ? 7'd99 : v;
    to_ascii = {8'h30 + 8'(s / 7'd10), 8'h30 + 8'(s % 7'd10)};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= 4'd0;
      hour_q <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      msec_q <= 7'd0;
      h1 <= 8'h00; h0 <= 8'h00; m1 <= 8'h00; m0 <= 8'h00;
      s1 <= 8'h00; s0 <= 8'h00; c1 <= 8'h00; c0 <= 8'h00;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        hour_q <= hour;
        min_q  <= min;
        sec_q  <= sec;
        msec_q <= msec;
      end
      if (state == LOAD) begin
        {h1, h0} <= to_ascii({2'b00, hour_q});
        {m1, m0} <= to_ascii({1'b0, min_q});
        {s1, s0} <= to_ascii({1'b0, sec_q});
        {c1, c0} <= to_ascii(msec_q);
        idx      <= 4'd0;
      end else if (push) begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      4'd0:  frame_byte = h1;
      4'd1:  frame_byte = h0;
      4'd2:  frame_byte = SEP_CHAR;
      4'd3:  frame_byte = m1;
      4'd4:  frame_byte = m0;
      4'd5:  frame_byte = SEP_CHAR;
      4'd6:  frame_byte = s1;
      4'd7:  frame_byte = s0;
      4'd8:  frame_byte = DOT_CHAR;
      4'd9:  frame_byte = c1;
      4'd10: frame_byte = c0;
`ifdef TIME_SENDER_CRLF_EN
      4'd11: frame_byte = 8'h0D;
      4'd12: frame_byte = 8'h0A;
`else
      4'd11: frame_byte = 8'h0A;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_data  = 8'h00;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = LOAD;
      end
      LOAD: next_state = SEND;
      SEND: begin
        // Byte stays on push_data while the FIFO is full so it is never dropped.
        push      = !tx_full;
        push_data = frame_byte;
        if (!tx_full && idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_time_ascii_sender.sv
// tb/tb_time_ascii_sender.sv - scoreboard bench for time_ascii_sender.
module tb_time_ascii_sender;

`ifdef TIME_SENDER_CRLF_EN
  localparam int NB = 13;
  localparam int DONE_OFS = 15;
`else
  localparam int NB = 12;
  localparam int DONE_OFS = 14;
`endif

  localparam logic [87:0] NOM = {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A,
                                 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38};
  localparam logic [87:0] SAT = {8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A,
                                 8'h30, 8'h39, 8'h2E, 8'h39, 8'h39};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] min = 6'd0;
  logic [5:0] sec = 6'd0;
  logic [6:0] msec = 7'd0;
  logic       tx_full = 1'b0;
  logic       push;
  logic [7:0] push_data;
  logic       busy;
  logic       done;

  time_ascii_sender dut (
    .clk(clk), .rst(rst), .start(start), .hour(hour), .min(min), .sec(sec),
    .msec(msec), .tx_full(tx_full), .push(push), .push_data(push_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  int push_cnt = 0;
  int first_push_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every push is matched against the head of the queue.
  always @(negedge clk) begin
    if (push) begin
      if (tx_full) check("push_while_full", 1, 0);
      if (exp_q.size() == 0) check("unexpected_push", int'(push_data), -1);
      else check("push_data", int'(push_data), int'(exp_q.pop_front()));
      push_cnt++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] frame_byte(input logic [87:0] v, input int i);
    if (i < 11) return v[87-8*i -: 8];
`ifdef TIME_SENDER_CRLF_EN
    return (i == 11) ? 8'h0D : 8'h0A;
`else
    return 8'h0A;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [87:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(frame_byte(v, i));
  endtask

  task automatic clear_stats();
    push_cnt = 0;
    first_push_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
  endtask

  task automatic fire(output int t);
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 80) begin
      step();
      k++;
    end
    if (done_cnt == 0) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic goto(input int c);
    int k = 0;
    while (cyc < c && k < 80) begin
      step();
      k++;
    end
  endtask

  int t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with start held high to show it is ignored.
    start = 1'b1;
    repeat (3) step();
    check("rst_push", int'(push), 0);
    check("rst_push_data", int'(push_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    start = 1'b0;
    rst = 1'b1;
    step();
    check("rst_start_ignored", int'(busy), 0);

    // Nominal frame
    set_time(12, 34, 56, 78);
    clear_stats();
    load_frame(NOM, NB);
    fire(t);
    check("load_busy", int'(busy), 1);
    wait_done("nominal");
    step(); step();
    check("nom_first_push", first_push_cyc, t + 2);
    check("nom_done_cycle", done_cyc, t + DONE_OFS);
    check("nom_done_pulses", done_cnt, 1);
    check("nom_push_count", push_cnt, NB);
    check("nom_idle_busy", int'(busy), 0);

    // Back-pressure while index 4 is pending
    clear_stats();
    load_frame(NOM, NB);
    fire(t);
    goto(t + 6);
    tx_full = 1'b1;
    goto(t + 8);
    check("bp_no_push", int'(push), 0);
    check("bp_held_data", int'(push_data), 8'h34);
    goto(t + 11);
    tx_full = 1'b0;
    wait_done("backpressure");
    step();
    check("bp_done_cycle", done_cyc, t + DONE_OFS + 5);
    check("bp_push_count", push_cnt, NB);

    // Snapshot and start-while-busy
    clear_stats();
    load_frame(NOM, NB);
    fire(t);
    goto(t + 5);
    hour = 5'd3;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("snapshot");
    repeat (6) step();
    check("snap_push_count", push_cnt, NB);
    check("snap_done_pulses", done_cnt, 1);
    check("snap_done_cycle", done_cyc, t + DONE_OFS);

    // Saturation
    set_time(0, 0, 9, 127);
    clear_stats();
    load_frame(SAT, NB);
    fire(t);
    wait_done("saturation");
    step();
    check("sat_push_count", push_cnt, NB);

    // Mid-frame reset after the 6th push, start held during reset
    set_time(12, 34, 56, 78);
    clear_stats();
    load_frame(NOM, 6);
    fire(t);
    goto(t + 7);
    rst = 1'b0;
    start = 1'b1;
    step();
    rst = 1'b1;
    start = 1'b0;
    check("mrst_push", int'(push), 0);
    check("mrst_busy", int'(busy), 0);
    step();
    check("mrst_start_ignored", int'(busy), 0);
    check("mrst_push_count", push_cnt, 6);
    check("mrst_queue_empty", exp_q.size(), 0);

    // Full frame after reset, then a start right after DONE
    clear_stats();
    load_frame(NOM, NB);
    fire(t);
    wait_done("after_reset");
    check("ar_push_count", push_cnt, NB);
    check("ar_done_cycle", done_cyc, t + DONE_OFS);
    check("b2b_idle_cycle", cyc, done_cyc + 1);
    clear_stats();
    load_frame(NOM, NB);
    fire(t);
    wait_done("back_to_back");
    step();
    check("b2b_first_push", first_push_cyc, t + 2);
    check("b2b_done_cycle", done_cyc, t + DONE_OFS);
    check("b2b_push_count", push_cnt, NB);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
